// File: rtl/soc_new_cpu_oci_dct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_new_cpu_oci_dct_pkg
// Purpose  : Shared constants and state encoding for the OCI data-trace
//            compression (DCT) packer.
// Contents : DCT_SYM_W, DCT_DEPTH, DCT_BUF_W, DCT_CNT_W, dct_state_t
// Revision : 1.0 - initial release
// ============================================================================
package soc_new_cpu_oci_dct_pkg;

  localparam int DCT_SYM_W = 2;
  localparam int DCT_DEPTH = 15;
  localparam int DCT_BUF_W = DCT_SYM_W * DCT_DEPTH;
  localparam int DCT_CNT_W = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    ENDED = 2'd2
  } dct_state_t;

endpackage
`default_nettype wire

// File: rtl/soc_new_cpu_oci_dct_shift.sv
`default_nettype none
// ============================================================================
// Module   : soc_new_cpu_oci_dct_shift
// Purpose  : Packing buffer and symbol count for the DCT packer. Each load
//            writes the symbol into the slot indexed by the current count and
//            increments the count; clear empties the frame.
// Ports    : clk, reset_n      - clock, async active-low reset
//            load, symbol      - append one symbol
//            clear             - discard buffer and count
//            buffer, count     - live frame contents
// Revision : 1.0 - initial release
// ============================================================================
module soc_new_cpu_oci_dct_shift
  import soc_new_cpu_oci_dct_pkg::*;
#(
  parameter int SYM_W = DCT_SYM_W,
  parameter int DEPTH = DCT_DEPTH,
  parameter int BUF_W = DCT_BUF_W,
  parameter int CNT_W = DCT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [SYM_W-1:0] symbol,
  output logic [BUF_W-1:0] buffer,
  output logic [CNT_W-1:0] count
);

  // The sequencer only loads while the count is below DEPTH, so the slot
  // index never runs past the buffer; untouched slots stay zero because
  // every clear wipes the whole buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer <= '0;
      count  <= '0;
    end else if (clear) begin
      buffer <= '0;
      count  <= '0;
    end else if (load) begin
      buffer[SYM_W*count +: SYM_W] <= symbol;
      count                        <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/soc_new_cpu_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : soc_new_cpu_oci_dct_packer
// Purpose  : Sequencer for the Nios II OCI data-trace compression path.
//            Packs up to DEPTH trace symbols into a frame, hands full or
//            flushed frames to the trace FIFO over valid/ready, and drains
//            the partial frame at end of test before raising test_has_ended.
// Ports    : clk, reset_n                 - clock, async active-low reset
//            sym_valid/sym_data/sym_ready - trace symbol input
//            flush_req                    - emit partial frame request
//            test_ending                  - end-of-test request (latched)
//            frm_valid/frm_ready          - frame handshake to FIFO
//            frm_buffer/frm_count         - frame payload and symbol count
//            dct_buffer/dct_count         - live packing state
//            test_has_ended               - drain complete, sticky
//            drop_count                   - rejected-symbol counter
// Options  : SOC_NEW_DCT_DROP_COUNTER_EN enables the drop_count register;
//            otherwise drop_count reads 0.
// Revision : 1.0 - initial release
// ============================================================================
module soc_new_cpu_oci_dct_packer
  import soc_new_cpu_oci_dct_pkg::*;
#(
  parameter int SYM_W = DCT_SYM_W,
  parameter int DEPTH = DCT_DEPTH,
  parameter int BUF_W = DCT_BUF_W,
  parameter int CNT_W = DCT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  output logic             sym_ready,
  input  logic             flush_req,
  input  logic             test_ending,
  output logic             frm_valid,
  input  logic             frm_ready,
  output logic [BUF_W-1:0] frm_buffer,
  output logic [CNT_W-1:0] frm_count,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             test_has_ended,
  output logic [15:0]      drop_count
);

  dct_state_t       state;
  dct_state_t       state_nxt;
  logic             ending;
  logic             accept;
  logic             load;
  logic             clear;
  logic [CNT_W-1:0] cnt_after;

  soc_new_cpu_oci_dct_shift #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH),
    .BUF_W (BUF_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .clear   (clear),
    .symbol  (sym_data),
    .buffer  (dct_buffer),
    .count   (dct_count)
  );

  assign accept = sym_valid && sym_ready;
  // Count as it will be after this cycle's accept, so a symbol arriving with
  // a flush or the DEPTH-th symbol is folded into the emitted frame.
  assign cnt_after = dct_count + CNT_W'(accept);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FILL;
      ending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (test_ending) begin
        ending <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sym_ready = 1'b0;
    frm_valid = 1'b0;
    load      = 1'b0;
    clear     = 1'b0;
    case (state)
      FILL: begin
        sym_ready = 1'b1;
        load      = accept;
        if (cnt_after == CNT_W'(DEPTH)) begin
          state_nxt = EMIT;
        end else if (cnt_after != '0 && (flush_req || ending)) begin
          state_nxt = EMIT;
        end else if (cnt_after == '0 && ending) begin
          state_nxt = ENDED;
        end
      end
      EMIT: begin
        frm_valid = 1'b1;
        if (frm_ready) begin
          clear     = 1'b1;
          state_nxt = ending ? ENDED : FILL;
        end
      end
      ENDED: begin
        state_nxt = ENDED;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // The live buffer cannot change outside FILL, so it doubles as the
  // held frame payload while frm_valid is high.
  assign frm_buffer     = dct_buffer;
  assign frm_count      = dct_count;
  assign test_has_ended = (state == ENDED);

`ifdef SOC_NEW_DCT_DROP_COUNTER_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (sym_valid && !sym_ready && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule
`default_nettype wire
